// File: rtl/cory_dist_if.sv
// Stream bundle for cory_dist: one tagged valid/ready input, R registered outputs.
// The slave modport is the distributor side, the master modport the producer/consumer side.
interface cory_dist_if #(
  parameter int N = 8,
  parameter int R = 2,
  parameter int D = R * N,
  parameter int S = (R > 1) ? $clog2(R) : 1
);
  logic         i_a_v;
  logic [N-1:0] i_a_d;
  logic [S-1:0] i_a_s;
  logic         i_a_b;
  logic         o_a_r;
  logic [R-1:0] o_zx_v;
  logic [D-1:0] o_zx_d;
  logic [R-1:0] i_zx_r;
  logic         o_err;

  modport slave (
    input  i_a_v, i_a_d, i_a_s, i_a_b, i_zx_r,
    output o_a_r, o_zx_v, o_zx_d, o_err
  );

  modport master (
    output i_a_v, i_a_d, i_a_s, i_a_b, i_zx_r,
    input  o_a_r, o_zx_v, o_zx_d, o_err
  );
endinterface

// File: rtl/cory_dist.sv
// Single-stream to R-stream distributor with a one-entry register stage per output port.
// Optional broadcast to all ports is built only when CORY_DIST_BCAST_EN is defined.
module cory_dist #(
  parameter int N = 8,
  parameter int R = 2,
  parameter int D = R * N,
  parameter int S = (R > 1) ? $clog2(R) : 1
) (
  input  logic          clk,
  input  logic          reset,
  cory_dist_if.slave    bus
);
  localparam logic [S:0] R_LIM = (S + 1)'(R);

  logic [R-1:0]        buf_v_q, buf_v_d;
  logic [R-1:0][N-1:0] buf_d_q, buf_d_d;
  logic                err_q, err_d;

  logic [R-1:0] ld_ok_s;
  logic [R-1:0] load_s;
  logic         in_range_s;
  logic         bcast_s;
  logic         a_r_s;
  logic         xfer_s;

`ifdef CORY_DIST_BCAST_EN
  assign bcast_s = bus.i_a_b;
`else
  logic unused_bcast_s;
  assign unused_bcast_s = bus.i_a_b;
  assign bcast_s        = 1'b0;
`endif

  // Input acceptance, routing decision and next state of every port buffer.
  always_comb begin
    ld_ok_s    = ~buf_v_q | bus.i_zx_r;
    in_range_s = ({1'b0, bus.i_a_s} < R_LIM);
    a_r_s      = 1'b0;
    load_s     = '0;
    buf_v_d    = buf_v_q;
    buf_d_d    = buf_d_q;

    if (reset) begin
      a_r_s = 1'b0;
    end else if (bcast_s) begin
      a_r_s = &ld_ok_s;
    end else if (in_range_s) begin
      a_r_s = ld_ok_s[bus.i_a_s];
    end else begin
      // Out-of-range beats are swallowed so a bad tag can never wedge the input.
      a_r_s = 1'b1;
    end

    xfer_s = bus.i_a_v && a_r_s;

    if (xfer_s && bcast_s) begin
      load_s = '1;
    end else if (xfer_s && in_range_s) begin
      load_s = {{(R-1){1'b0}}, 1'b1} << bus.i_a_s;
    end else begin
      load_s = '0;
    end

    err_d = xfer_s && !bcast_s && !in_range_s;

    // A load wins over a drain, so load+drain in one cycle keeps the port valid.
    for (int k = 0; k < R; k++) begin
      if (load_s[k]) begin
        buf_v_d[k] = 1'b1;
        buf_d_d[k] = bus.i_a_d;
      end else if (buf_v_q[k] && bus.i_zx_r[k]) begin
        buf_v_d[k] = 1'b0;
        buf_d_d[k] = buf_d_q[k];
      end else begin
        buf_v_d[k] = buf_v_q[k];
        buf_d_d[k] = buf_d_q[k];
      end
    end
  end

  // Port buffers and the discard flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_v_q <= '0;
      buf_d_q <= '0;
      err_q   <= 1'b0;
    end else begin
      buf_v_q <= buf_v_d;
      buf_d_q <= buf_d_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_a_r  = a_r_s;
  assign bus.o_zx_v = buf_v_q;
  assign bus.o_zx_d = buf_d_q;
  assign bus.o_err  = err_q;
endmodule
